// File: rtl/jttrack_vtiming.sv
// rtl/jttrack_vtiming.sv - Track'n Field video timing generator (counters, blanking, sync, line strobe)
//
// Purpose:
//   Generates the pixel/line counters and the blanking, sync and line-start
//   strobes for the video stage. Everything advances only on pxl_cen, and
//   every output is a flop, so counters and decoded flags are skew-free.
//
// Ports:
//   clk      in   48 MHz system clock
//   rst_n    in   asynchronous active-low reset
//   pxl_cen  in   pixel clock enable (single-cycle pulses)
//   hs_adj   in   signed HS position trim in pixels (JTTRACK_VTIMING_ADJ_EN only)
//   vs_adj   in   signed VS position trim in lines  (JTTRACK_VTIMING_ADJ_EN only)
//   hdump    out  current pixel column, 0..HTOTAL-1
//   vdump    out  current line, 0..VTOTAL-1
//   vrender  out  line being prepared, (vdump+1) mod VTOTAL
//   hinit    out  high while hdump==0
//   LHBL     out  horizontal blank, active low
//   LVBL     out  vertical blank, active low
//   HS       out  horizontal sync, active high
//   VS       out  vertical sync, active high
//
// Optional feature macro: JTTRACK_VTIMING_ADJ_EN adds hs_adj/vs_adj, which
// shift the sync windows (modulo the line/frame length). The trims are
// captured only at the frame start so sync never moves mid-frame.

module jttrack_vtiming #(
  parameter int HTOTAL   = 384,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 296,
  parameter int HS_END   = 328,
  parameter int VTOTAL   = 264,
  parameter int VB_START = 240,
  parameter int VB_END   = 16,
  parameter int VS_START = 248,
  parameter int VS_END   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
`ifdef JTTRACK_VTIMING_ADJ_EN
  input  logic signed [3:0] hs_adj,
  input  logic signed [3:0] vs_adj,
`endif
  output logic [8:0]        hdump,
  output logic [8:0]        vdump,
  output logic [8:0]        vrender,
  output logic              hinit,
  output logic              LHBL,
  output logic              LVBL,
  output logic              HS,
  output logic              VS
);

  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);

  // Illegal timing sets stop elaboration rather than producing odd video.
  if (HTOTAL > 511 || VTOTAL > 511 ||
      !(HS_START < HS_END && HS_END <= HTOTAL) ||
      !(VS_START < VS_END && VS_END <= VTOTAL) ||
      !(HB_END < HB_START) || !(VB_END < VB_START)) begin : g_param_check
    $fatal(1, "jttrack_vtiming: illegal timing parameters");
  end

  // Half-open window test. Bounds arrive as arguments so a zero lower
  // bound does not turn into a constant comparison.
  function automatic logic in_range(input logic [9:0] c,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

`ifdef JTTRACK_VTIMING_ADJ_EN
  // base+adj folded back into 0..total-1; one correction step is enough
  // because base <= total and |adj| <= 8.
  function automatic logic [9:0] wrap_add(input logic [9:0]        base,
                                          input logic signed [3:0] adj,
                                          input logic [9:0]        total);
    logic signed [11:0] s;
    s = $signed({2'b00, base}) + $signed({{8{adj[3]}}, adj});
    if (s < 0) begin
      s = s + $signed({2'b00, total});
    end else if (s >= $signed({2'b00, total})) begin
      s = s - $signed({2'b00, total});
    end
    return s[9:0];
  endfunction

  // A shifted window may straddle the counter wrap: lo >= hi means
  // "from lo up to the end, plus from 0 up to hi".
  function automatic logic in_window(input logic [9:0] c,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (lo < hi) ? in_range(c, lo, hi) : ((c >= lo) || (c < hi));
  endfunction

  logic signed [3:0] hs_adj_q, hs_adj_d;
  logic signed [3:0] vs_adj_q, vs_adj_d;
  logic [9:0]        hs_lo, hs_hi, vs_lo, vs_hi;
`endif

  logic [8:0] hdump_q, hdump_d;
  logic [8:0] vdump_q, vdump_d;
  logic [8:0] vrender_q, vrender_d;
  logic       hinit_q, hinit_d;
  logic       lhbl_q, lhbl_d;
  logic       lvbl_q, lvbl_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  // Counter values for the coming update; all flags decode from these so
  // they land in the same cycle as the counters they describe.
  logic [8:0] h_next, v_next, vr_next;
  logic       hs_next, vs_next;

  always_comb begin
    h_next = hdump_q + 9'd1;
    v_next = vdump_q;
    if (hdump_q == H_LAST) begin
      h_next = '0;
      v_next = (vdump_q == V_LAST) ? 9'd0 : vdump_q + 9'd1;
    end
    vr_next = (v_next == V_LAST) ? 9'd0 : v_next + 9'd1;

`ifdef JTTRACK_VTIMING_ADJ_EN
    hs_adj_d = hs_adj_q;
    vs_adj_d = vs_adj_q;
    // The frame-start update already uses the freshly sampled trims.
    if (pxl_cen && h_next == 9'd0 && v_next == 9'd0) begin
      hs_adj_d = hs_adj;
      vs_adj_d = vs_adj;
    end
    hs_lo   = wrap_add(10'(HS_START), hs_adj_d, 10'(HTOTAL));
    hs_hi   = wrap_add(10'(HS_END),   hs_adj_d, 10'(HTOTAL));
    vs_lo   = wrap_add(10'(VS_START), vs_adj_d, 10'(VTOTAL));
    vs_hi   = wrap_add(10'(VS_END),   vs_adj_d, 10'(VTOTAL));
    hs_next = in_window({1'b0, h_next}, hs_lo, hs_hi);
    vs_next = in_window({1'b0, v_next}, vs_lo, vs_hi);
`else
    hs_next = in_range({1'b0, h_next}, 10'(HS_START), 10'(HS_END));
    vs_next = in_range({1'b0, v_next}, 10'(VS_START), 10'(VS_END));
`endif

    hdump_d   = hdump_q;
    vdump_d   = vdump_q;
    vrender_d = vrender_q;
    hinit_d   = hinit_q;
    lhbl_d    = lhbl_q;
    lvbl_d    = lvbl_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    if (pxl_cen) begin
      hdump_d   = h_next;
      vdump_d   = v_next;
      vrender_d = vr_next;
      hinit_d   = (h_next == 9'd0);
      lhbl_d    = in_range({1'b0, h_next}, 10'(HB_END), 10'(HB_START));
      lvbl_d    = in_range({1'b0, v_next}, 10'(VB_END), 10'(VB_START));
      hs_d      = hs_next;
      vs_d      = vs_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdump_q   <= '0;
      vdump_q   <= '0;
      vrender_q <= 9'd1;
      hinit_q   <= 1'b0;
      lhbl_q    <= 1'b0;
      lvbl_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
`ifdef JTTRACK_VTIMING_ADJ_EN
      hs_adj_q  <= '0;
      vs_adj_q  <= '0;
`endif
    end else begin
      hdump_q   <= hdump_d;
      vdump_q   <= vdump_d;
      vrender_q <= vrender_d;
      hinit_q   <= hinit_d;
      lhbl_q    <= lhbl_d;
      lvbl_q    <= lvbl_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
`ifdef JTTRACK_VTIMING_ADJ_EN
      hs_adj_q  <= hs_adj_d;
      vs_adj_q  <= vs_adj_d;
`endif
    end
  end

  assign hdump   = hdump_q;
  assign vdump   = vdump_q;
  assign vrender = vrender_q;
  assign hinit   = hinit_q;
  assign LHBL    = lhbl_q;
  assign LVBL    = lvbl_q;
  assign HS      = hs_q;
  assign VS      = vs_q;

endmodule

// File: tb/tb_jttrack_vtiming.sv
// tb/tb_jttrack_vtiming.sv - self-checking bench for jttrack_vtiming (default and reduced timing instances)

module tb_jttrack_vtiming;

  localparam int S_HT  = 320, S_HBS = 240, S_HBE = 8,  S_HSS = 260, S_HSE = 292;
  localparam int S_VT  = 12,  S_VBS = 10,  S_VBE = 2,  S_VSS = 11,  S_VSE = 12;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [8:0] vr;
    logic       hinit;
    logic       lhbl;
    logic       lvbl;
    logic       hs;
    logic       vs;
  } obs_t;

  typedef struct {
    int ht, hbs, hbe, hss, hse, vt, vbs, vbe, vss, vse;
  } tp_t;

  typedef struct {
    int   adv;
    int   gap;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pxl_cen = 1'b0;
  logic signed [3:0] d_hs_adj = '0, d_vs_adj = '0;
  logic signed [3:0] s_hs_adj = '0, s_vs_adj = '0;

  logic [8:0] d_hdump, d_vdump, d_vrender, s_hdump, s_vdump, s_vrender;
  logic d_hinit, d_lhbl, d_lvbl, d_hs, d_vs;
  logic s_hinit, s_lhbl, s_lvbl, s_hs, s_vs;
  obs_t o_d, o_s;

  assign o_d = {d_hdump, d_vdump, d_vrender, d_hinit, d_lhbl, d_lvbl, d_hs, d_vs};
  assign o_s = {s_hdump, s_vdump, s_vrender, s_hinit, s_lhbl, s_lvbl, s_hs, s_vs};

  always #5 clk = ~clk;

  jttrack_vtiming dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
`ifdef JTTRACK_VTIMING_ADJ_EN
    .hs_adj(d_hs_adj), .vs_adj(d_vs_adj),
`endif
    .hdump(d_hdump), .vdump(d_vdump), .vrender(d_vrender), .hinit(d_hinit),
    .LHBL(d_lhbl), .LVBL(d_lvbl), .HS(d_hs), .VS(d_vs)
  );

  jttrack_vtiming #(
    .HTOTAL(S_HT), .HB_START(S_HBS), .HB_END(S_HBE), .HS_START(S_HSS), .HS_END(S_HSE),
    .VTOTAL(S_VT), .VB_START(S_VBS), .VB_END(S_VBE), .VS_START(S_VSS), .VS_END(S_VSE)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
`ifdef JTTRACK_VTIMING_ADJ_EN
    .hs_adj(s_hs_adj), .vs_adj(s_vs_adj),
`endif
    .hdump(s_hdump), .vdump(s_vdump), .vrender(s_vrender), .hinit(s_hinit),
    .LHBL(s_lhbl), .LVBL(s_lvbl), .HS(s_hs), .VS(s_vs)
  );

  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  int   s_hadj_eff = 0, s_vadj_eff = 0;
  tp_t  T_D, T_S;
  vec_t vec[12];

  function automatic int pmod(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  // Expected outputs after n pixel updates since reset, from the counting
  // and window rules directly. Sync is "distance past the start, modulo the
  // period, is below the window width".
  function automatic obs_t model(input int cnt, input tp_t p, input int hadj, input int vadj);
    obs_t o;
    int h, v;
    o = '0;
    if (cnt == 0) begin
      o.vr = 9'd1;
      return o;
    end
    h = cnt % p.ht;
    v = (cnt / p.ht) % p.vt;
    o.h     = 9'(h);
    o.v     = 9'(v);
    o.vr    = 9'((v + 1) % p.vt);
    o.hinit = (h == 0);
    o.lhbl  = (h >= p.hbe) && (h < p.hbs);
    o.lvbl  = (v >= p.vbe) && (v < p.vbs);
    o.hs    = pmod(h - p.hss - hadj, p.ht) < (p.hse - p.hss);
    o.vs    = pmod(v - p.vss - vadj, p.vt) < (p.vse - p.vss);
    return o;
  endfunction

  function automatic obs_t mk(input int h, input int v, input int vr, input bit hi,
                              input bit lh, input bit lv, input bit hs, input bit vs);
    obs_t o;
    o.h = 9'(h); o.v = 9'(v); o.vr = 9'(vr);
    o.hinit = hi; o.lhbl = lh; o.lvbl = lv; o.hs = hs; o.vs = vs;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (n=%0d): got h=%0d v=%0d vr=%0d hinit=%b lhbl=%b lvbl=%b hs=%b vs=%b, expected h=%0d v=%0d vr=%0d hinit=%b lhbl=%b lvbl=%b hs=%b vs=%b",
               name, n, act.h, act.v, act.vr, act.hinit, act.lhbl, act.lvbl, act.hs, act.vs,
               exp.h, exp.v, exp.vr, exp.hinit, exp.lhbl, exp.lvbl, exp.hs, exp.vs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pxl_cen pulse followed by gap-1 idle clocks; both instances are
  // compared after the update and again at the end of the idle stretch.
  task automatic pulse(input int gap);
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    n++;
`ifdef JTTRACK_VTIMING_ADJ_EN
    if ((n % T_S.ht) == 0 && ((n / T_S.ht) % T_S.vt) == 0) begin
      s_hadj_eff = int'(s_hs_adj);
      s_vadj_eff = int'(s_vs_adj);
    end
`endif
    check("dflt_update", o_d, model(n, T_D, 0, 0));
    check("small_update", o_s, model(n, T_S, s_hadj_eff, s_vadj_eff));
    if (gap > 1) begin
      repeat (gap - 1) @(posedge clk);
      #1;
      check("dflt_hold", o_d, model(n, T_D, 0, 0));
      check("small_hold", o_s, model(n, T_S, s_hadj_eff, s_vadj_eff));
    end
  endtask

  initial begin
    int lhbl_cnt, hs_cnt, hinit_cnt;
    T_D = '{384, 256, 0, 296, 328, 264, 240, 16, 248, 256};
    T_S = '{S_HT, S_HBS, S_HBE, S_HSS, S_HSE, S_VT, S_VBS, S_VBE, S_VSS, S_VSE};

    // adv pulses at the given spacing, then the default instance must match exp
    vec[0]  = '{1,    8, mk(1,   0,  1,  0, 1, 0, 0, 0)};
    vec[1]  = '{383,  8, mk(0,   1,  2,  1, 1, 0, 0, 0)};
    vec[2]  = '{1,    8, mk(1,   1,  2,  0, 1, 0, 0, 0)};
    vec[3]  = '{254,  8, mk(255, 1,  2,  0, 1, 0, 0, 0)};
    vec[4]  = '{1,    8, mk(256, 1,  2,  0, 0, 0, 0, 0)};
    vec[5]  = '{39,   8, mk(295, 1,  2,  0, 0, 0, 0, 0)};
    vec[6]  = '{1,    8, mk(296, 1,  2,  0, 0, 0, 1, 0)};
    vec[7]  = '{31,   8, mk(327, 1,  2,  0, 0, 0, 1, 0)};
    vec[8]  = '{1,    8, mk(328, 1,  2,  0, 0, 0, 0, 0)};
    vec[9]  = '{55,   8, mk(383, 1,  2,  0, 0, 0, 0, 0)};
    vec[10] = '{5376, 1, mk(383, 15, 16, 0, 0, 0, 0, 0)};
    vec[11] = '{1,    1, mk(0,   16, 17, 1, 1, 1, 0, 0)};

    // Reset state, including a few clocks of pxl_cen while held in reset.
    repeat (3) @(posedge clk);
    #1;
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    check("reset_dflt", o_d, mk(0, 0, 1, 0, 0, 0, 0, 0));
    check("reset_small", o_s, model(0, T_S, 0, 0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("release_hold", o_d, mk(0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vec[i].adv; k++) pulse(vec[i].gap);
      check($sformatf("vec%0d", i), o_d, vec[i].exp);
    end

    // Irregular enable spacing; the small instance also gets sync trims
    // mid-frame when the adjust feature is built in.
`ifdef JTTRACK_VTIMING_ADJ_EN
    s_hs_adj = -4'sd4;
    s_vs_adj = 4'sd3;
`endif
    for (int i = 0; i < 1000; i++) pulse(int'($urandom_range(1, 20)));

    // Fast run to line 100, pixel 200 of the default frame; the small
    // instance wraps its frame several times on the way.
    while (n < 100 * 384 + 200) pulse(1);
    check("pre_reset", o_d, mk(200, 100, 101, 0, 1, 1, 0, 0));

    // Asynchronous reset between clock edges, no pxl_cen.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dflt", o_d, mk(0, 0, 1, 0, 0, 0, 0, 0));
    check("async_reset_small", o_s, model(0, T_S, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    s_hadj_eff = 0;
    s_vadj_eff = 0;
    @(posedge clk);
    #1;
    check("post_release", o_d, mk(0, 0, 1, 0, 0, 0, 0, 0));
    pulse(8);
    check("restart", o_d, mk(1, 0, 1, 0, 1, 0, 0, 0));

    // One full default line: blank, sync and line-strobe widths.
    lhbl_cnt = 0; hs_cnt = 0; hinit_cnt = 0;
    for (int i = 0; i < 384; i++) begin
      pulse(1);
      lhbl_cnt  += int'(d_lhbl);
      hs_cnt    += int'(d_hs);
      hinit_cnt += int'(d_hinit);
    end
    check_int("line_lhbl_count", lhbl_cnt, 256);
    check_int("line_hs_count", hs_cnt, 32);
    check_int("line_hinit_count", hinit_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
